// File: rtl/codeword_pkg.sv
// rtl/codeword_pkg.sv - shared constants and types for the serial codeword detector
package codeword_pkg;

    // Widths of the legacy fixed detector this block replaces
    localparam int CW_W     = 12;
    localparam int CW_CNT_W = 16;

    // Pattern loaded at reset; MSB is the first bit received
    localparam logic [CW_W-1:0] CW_DEFAULT = 12'b101111111111;

    // What the datapath does in a given cycle; a pattern load outranks a bit
    typedef enum logic [1:0] {
        EV_IDLE  = 2'd0,
        EV_SHIFT = 2'd1,
        EV_LOAD  = 2'd2
    } cw_event_e;

endpackage

// File: rtl/codeword_detector_if.sv
// rtl/codeword_detector_if.sv - stream, control and status bundle of the codeword detector
interface codeword_detector_if #(
    parameter int W     = 12,
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             overlap_en;
    logic             pattern_load;
    logic [W-1:0]     pattern_in;
    logic [W-1:0]     mask_in;
    logic             count_clr;
    logic             detect;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    // Producer side: LFSR feed plus control/readout logic
    modport master (
        output bit_in, bit_valid, overlap_en, pattern_load,
               pattern_in, mask_in, count_clr,
        input  detect, match_count, armed
    );

    // Detector side
    modport slave (
        input  bit_in, bit_valid, overlap_en, pattern_load,
               pattern_in, mask_in, count_clr,
        output detect, match_count, armed
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear priority over increment
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;
    logic             w_full;

    assign w_full = &r_q;
    assign q      = r_q;

    // Clear wins over a same-cycle increment; the count parks at all ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !w_full) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule

// File: rtl/codeword_detector.sv
// rtl/codeword_detector.sv - serial masked-pattern detector with overlap control and match counter
module codeword_detector
    import codeword_pkg::*;
#(
    parameter int             W       = CW_W,
    parameter logic [W-1:0]   PATTERN = CW_DEFAULT,
    parameter int             CNT_W   = CW_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    codeword_detector_if.slave  bus
);

    // fill counts 0..W inclusive, so it needs one value more than W positions
    localparam int          FW     = $clog2(W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(W);

    logic [W-1:0]  r_shreg;
    logic [W-1:0]  r_pat;
    logic [W-1:0]  r_mask;
    logic [FW-1:0] r_fill;
    logic          r_detect;
    logic          r_armed;

    cw_event_e     w_event;
    logic [W-1:0]  w_shreg_shift;
    logic [FW-1:0] w_fill_inc;
    logic          w_match;
    logic [W-1:0]  w_shreg_d;
    logic [W-1:0]  w_pat_d;
    logic [W-1:0]  w_mask_d;
    logic [FW-1:0] w_fill_d;

    // Classify the cycle: a load discards any bit presented alongside it
    always_comb begin
        w_event = EV_IDLE;
        if (bus.pattern_load) begin
            w_event = EV_LOAD;
        end else if (bus.bit_valid) begin
            w_event = EV_SHIFT;
        end
    end

    assign w_shreg_shift = {r_shreg[W-2:0], bus.bit_in};
    assign w_fill_inc    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;

    // Masked compare is always evaluated; the fill gate keeps stale zeros from matching
    assign w_match = (w_event == EV_SHIFT)
                  && (w_fill_inc == FILL_FULL)
                  && (((w_shreg_shift ^ r_pat) & r_mask) == '0);

    // Next-state for shift register, fill and the loadable pattern/mask
    always_comb begin
        w_shreg_d = r_shreg;
        w_fill_d  = r_fill;
        w_pat_d   = r_pat;
        w_mask_d  = r_mask;
        case (w_event)
            EV_LOAD: begin
                w_pat_d   = bus.pattern_in;
                w_mask_d  = bus.mask_in;
                w_shreg_d = '0;
                w_fill_d  = '0;
            end
            EV_SHIFT: begin
                if (w_match && !bus.overlap_en) begin
                    // Non-overlapping: the next match must be built from W fresh bits
                    w_shreg_d = '0;
                    w_fill_d  = '0;
                end else begin
                    w_shreg_d = w_shreg_shift;
                    w_fill_d  = w_fill_inc;
                end
            end
            default: begin
                w_shreg_d = r_shreg;
                w_fill_d  = r_fill;
            end
        endcase
    end

    // Register datapath state; armed and detect are registered alongside fill
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_fill   <= '0;
            r_pat    <= PATTERN;
            r_mask   <= '1;
            r_detect <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_shreg  <= w_shreg_d;
            r_fill   <= w_fill_d;
            r_pat    <= w_pat_d;
            r_mask   <= w_mask_d;
            r_detect <= w_match;
            r_armed  <= (w_fill_d == FILL_FULL);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.count_clr),
        .inc (w_match),
        .q   (bus.match_count)
    );

    assign bus.detect = r_detect;
    assign bus.armed  = r_armed;

endmodule

// File: tb/tb_codeword_detector.sv
// tb/tb_codeword_detector.sv - directed vector bench for codeword_detector
module tb_codeword_detector;
    import codeword_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    codeword_detector_if #(.W(12), .CNT_W(16)) ifa ();
    codeword_detector_if #(.W(4),  .CNT_W(2))  ifb ();

    codeword_detector #(
        .W       (12),
        .PATTERN (12'b101111111111),
        .CNT_W   (16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    codeword_detector #(
        .W       (4),
        .PATTERN (4'b1010),
        .CNT_W   (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    typedef struct {
        logic       rst;
        logic       b;
        logic       v;
        logic       ov;
        logic       ld;
        logic [3:0] pat;
        logic [3:0] msk;
        logic       clr;
        logic       det;
        logic [1:0] cnt;
        logic       arm;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic v, input logic ov, input logic ld,
                       input logic [3:0] pat, input logic [3:0] msk, input logic clr,
                       input logic det, input logic [1:0] cnt, input logic arm);
        vec_t e;
        e.rst = r; e.b = b; e.v = v; e.ov = ov; e.ld = ld;
        e.pat = pat; e.msk = msk; e.clr = clr;
        e.det = det; e.cnt = cnt; e.arm = arm;
        vq.push_back(e);
    endtask

    task automatic step_a(input logic r, input logic b, input logic v);
        rst_a          = r;
        ifa.bit_in     = b;
        ifa.bit_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input int idx, input logic det, input logic [15:0] cnt, input logic arm);
        chk({nm, "_detect"}, idx, 32'(ifa.detect), 32'(det));
        chk({nm, "_count"},  idx, 32'(ifa.match_count), 32'(cnt));
        chk({nm, "_armed"},  idx, 32'(ifa.armed), 32'(arm));
    endtask

    logic [11:0] full_pat;
    logic [4:0]  part_pat;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.bit_in = 1'b0; ifa.bit_valid = 1'b0; ifa.overlap_en = 1'b1;
        ifa.pattern_load = 1'b0; ifa.pattern_in = '0; ifa.mask_in = '0; ifa.count_clr = 1'b0;
        ifb.bit_in = 1'b0; ifb.bit_valid = 1'b0; ifb.overlap_en = 1'b1;
        ifb.pattern_load = 1'b0; ifb.pattern_in = '0; ifb.mask_in = '0; ifb.count_clr = 1'b0;
        full_pat = 12'b101111111111;
        part_pat = 5'b10111;

        // W=4, CNT_W=2, reset pattern 1010
        //   rst  b     v     ov    ld    pat      msk      clr   det   cnt    arm
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // 0 reset
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // overlap 1010 10
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1); // 6
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b1); // idle + clr
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0); // 8 load
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // non-overlap
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0); // 12
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b1101, 1'b1, 1'b0, 2'd0, 1'b0); // 15 mask third bit
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1); // 19 1000 matches
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b1101, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1); // 24 1110 no match
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0); // 25 all ones
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1); // saturated
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1); // 34 clr beats inc
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0); // 36 zero mask
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b1); // 42 idle holds
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0); // 43 overlap off
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0); // 44 load, bit dropped
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // 47 fill 3 only
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // 49 reset restores 1010
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1);

        // Default-configuration DUT: reset
        step_a(1'b1, 1'b0, 1'b0);
        chk_a("a_reset", 0, 1'b0, 16'd0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            rst_b            = vq[i].rst;
            ifb.bit_in       = vq[i].b;
            ifb.bit_valid    = vq[i].v;
            ifb.overlap_en   = vq[i].ov;
            ifb.pattern_load = vq[i].ld;
            ifb.pattern_in   = vq[i].pat;
            ifb.mask_in      = vq[i].msk;
            ifb.count_clr    = vq[i].clr;
            @(posedge clk);
            #1;
            chk("b_detect", i, 32'(ifb.detect),      32'(vq[i].det));
            chk("b_count",  i, 32'(ifb.match_count), 32'(vq[i].cnt));
            chk("b_armed",  i, 32'(ifb.armed),       32'(vq[i].arm));
        end

        // Default pattern, overlap on: detect and armed only after bit 12
        for (int i = 11; i >= 0; i--) begin
            step_a(1'b0, full_pat[i], 1'b1);
            chk_a("a_stream", 11 - i, (i == 0), (i == 0) ? 16'd1 : 16'd0, (i == 0));
        end
        step_a(1'b0, 1'b0, 1'b0);
        chk_a("a_pulse_end", 0, 1'b0, 16'd1, 1'b1);

        // Partial pattern then reset: counter cleared, partial match discarded
        for (int i = 4; i >= 0; i--) begin
            step_a(1'b0, part_pat[i], 1'b1);
            chk_a("a_partial", 4 - i, 1'b0, 16'd1, 1'b1);
        end
        step_a(1'b1, 1'b1, 1'b1);
        chk_a("a_midrst", 0, 1'b0, 16'd0, 1'b0);
        for (int i = 11; i >= 0; i--) begin
            step_a(1'b0, full_pat[i], 1'b1);
            chk_a("a_after_rst", 11 - i, (i == 0), (i == 0) ? 16'd1 : 16'd0, (i == 0));
        end
        step_a(1'b0, 1'b0, 1'b0);
        chk_a("a_once", 0, 1'b0, 16'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
